// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared build-time defaults and helper types for the UART
// receive FIFO slice.
//   UART_RX_FIFO_DEPTH_LOG2 : default log2 entry count (4 -> 16 entries)
//   UART_RX_TIMEOUT_BITS    : idle bit-times before timeout (40 = four 10-bit chars)
// Either macro may be predefined on the command line to override the default.
`ifndef UART_RX_FIFO_DEPTH_LOG2
`define UART_RX_FIFO_DEPTH_LOG2 4
`endif
`ifndef UART_RX_TIMEOUT_BITS
`define UART_RX_TIMEOUT_BITS 40
`endif

package uart_rx_fifo_pkg;

    localparam int unsigned RX_DATA_W          = 8;
    localparam int unsigned RX_FIFO_DEPTH_LOG2 = `UART_RX_FIFO_DEPTH_LOG2;
    localparam int unsigned RX_BITDUR_W        = 16;
    localparam int unsigned RX_TIMEOUT_BITS    = `UART_RX_TIMEOUT_BITS;

    // Per-cycle FIFO operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundle of the deserializer write port, CPU read port,
// status and timeout configuration for uart_rx_fifo.
//   master : driver side (deserializer + CPU register block)
//   slave  : FIFO side
// Signals: rst_soft, wr_en, wr_data, rd_en, clr_overrun, bit_duration (to FIFO);
//          rd_data, rd_valid, level, full, overrun, timeout (from FIFO).
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned BITDUR_W   = 16
);
    logic                  rst_soft;
    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_en;
    logic                  clr_overrun;
    logic [BITDUR_W-1:0]   bit_duration;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic [DEPTH_LOG2:0]   level;
    logic                  full;
    logic                  overrun;
    logic                  timeout;

    modport master (
        output rst_soft, wr_en, wr_data, rd_en, clr_overrun, bit_duration,
        input  rd_data, rd_valid, level, full, overrun, timeout
    );

    modport slave (
        input  rst_soft, wr_en, wr_data, rd_en, clr_overrun, bit_duration,
        output rd_data, rd_valid, level, full, overrun, timeout
    );
endinterface

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout: idle-timeout detector for the RX FIFO.
// A prescaler counts bit_duration clk cycles per bit-time; a saturating bit
// counter counts LIMIT_BITS bit-times. timeout rises on the cycle the bit count
// reaches LIMIT_BITS and holds until restart/rst_soft.
// Ports:
//   clk, rst       : clock, async active-high reset
//   rst_soft       : synchronous clear
//   restart        : accepted write/read or FIFO empty this cycle
//   bit_duration   : clk cycles per bit; 0 disables (timeout held low)
//   timeout        : registered idle-timeout flag
// Only instantiated when UART_RX_TIMEOUT_EN is defined.
module uart_rx_timeout
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned BITDUR_W   = RX_BITDUR_W,
    parameter int unsigned LIMIT_BITS = RX_TIMEOUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_soft,
    input  logic                restart,
    input  logic [BITDUR_W-1:0] bit_duration,
    output logic                timeout
);
    localparam int unsigned              BITCNT_W   = $clog2(LIMIT_BITS + 1);
    localparam logic [BITCNT_W-1:0]      BITCNT_MAX = BITCNT_W'(LIMIT_BITS);

    logic [BITDUR_W-1:0] presc_q, presc_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic                timeout_q, timeout_d;
    logic                clear;
    logic                bit_tick;

    always_comb begin
        presc_d   = presc_q;
        bitcnt_d  = bitcnt_q;
        timeout_d = timeout_q;
        clear     = rst_soft || restart || (bit_duration == '0);
        // >= rather than == so a shrinking bit_duration cannot strand the prescaler
        bit_tick  = (presc_q >= bit_duration - BITDUR_W'(1));
        if (clear) begin
            presc_d   = '0;
            bitcnt_d  = '0;
            timeout_d = 1'b0;
        end else if (bitcnt_q != BITCNT_MAX) begin
            if (bit_tick) begin
                presc_d  = '0;
                bitcnt_d = bitcnt_q + BITCNT_W'(1);
                if (bitcnt_d == BITCNT_MAX) begin
                    timeout_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + BITDUR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            bitcnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            bitcnt_q  <= bitcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between the UART RX deserializer and
// the CPU register interface.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : uart_rx_fifo_if.slave (write strobe/data, pop strobe, overrun clear,
//          soft reset, bit_duration; rd_data/rd_valid/level/full/overrun/timeout)
// Macro UART_RX_TIMEOUT_EN builds the idle-timeout detector; without it
// timeout is tied 0 and bit_duration is ignored.
// All outputs come from registered state only.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = RX_DATA_W,
    parameter int unsigned DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
    parameter int unsigned BITDUR_W   = RX_BITDUR_W
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned         DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overrun_q, overrun_d;

    logic     empty;
    logic     full_int;
    logic     wr_acc;
    logic     rd_acc;
    logic     drop;
    fifo_op_e op;

    always_comb begin
        empty    = (level_q == '0);
        full_int = (level_q == LVL_FULL);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_acc   = bus.wr_en && (!full_int || bus.rd_en);
        rd_acc   = bus.rd_en && !empty;
        drop     = bus.wr_en && full_int && !bus.rd_en;
        op       = fifo_op(wr_acc, rd_acc);

        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        if (bus.rst_soft) begin
            wptr_d    = '0;
            rptr_d    = '0;
            level_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (wr_acc) begin
                mem_d[wptr_q] = bus.wr_data;
                wptr_d        = wptr_q + DEPTH_LOG2'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + DEPTH_LOG2'(1);
            end
            case (op)
                OP_PUSH: level_d = level_q + (DEPTH_LOG2 + 1)'(1);
                OP_POP:  level_d = level_q - (DEPTH_LOG2 + 1)'(1);
                default: level_d = level_q;
            endcase
            // A drop in the same cycle as clr_overrun keeps the flag set.
            if (drop) begin
                overrun_d = 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.rd_data  = empty ? '0 : mem_q[rptr_q];
    assign bus.rd_valid = !empty;
    assign bus.level    = level_q;
    assign bus.full     = full_int;
    assign bus.overrun  = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
    logic to_restart;
    assign to_restart = wr_acc || rd_acc || empty;

    uart_rx_timeout #(
        .BITDUR_W   (BITDUR_W),
        .LIMIT_BITS (RX_TIMEOUT_BITS)
    ) u_timeout (
        .clk          (clk),
        .rst          (rst),
        .rst_soft     (bus.rst_soft),
        .restart      (to_restart),
        .bit_duration (bus.bit_duration),
        .timeout      (bus.timeout)
    );
`else
    logic [BITDUR_W-1:0] unused_bit_duration;
    assign unused_bit_duration = bus.bit_duration;
    assign bus.timeout         = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo.
// Reference model: a byte queue plus an overrun bit and an idle-cycle counter
// (timeout = idle cycles >= 40 * bit_duration while non-empty, only when
// UART_RX_TIMEOUT_EN is defined).
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    uart_rx_fifo_if #(.DATA_W(8), .DEPTH_LOG2(4), .BITDUR_W(16)) bus ();

    uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .BITDUR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic [7:0]  mq [$];
    logic        m_ov;
    int unsigned m_idle;

    function automatic logic m_timeout();
        return TO_EN && (bus.bit_duration != 16'd0) && (mq.size() != 0)
               && (m_idle >= 40 * int'(bus.bit_duration));
    endfunction

    // {rd_valid, rd_data, level, full, overrun, timeout}
    function automatic logic [16:0] m_outs();
        logic [7:0] head;
        head = (mq.size() != 0) ? mq[0] : 8'h00;
        return {mq.size() != 0, head, 5'(mq.size()), mq.size() == DEPTH, m_ov, m_timeout()};
    endfunction

    function automatic logic [16:0] dut_outs();
        return {bus.rd_valid, bus.rd_data, bus.level, bus.full, bus.overrun, bus.timeout};
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ov   = 1'b0;
        m_idle = 0;
    endfunction

    // One clock: drive inputs, advance the model, leave time at posedge+1.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic s);
        bit full_m, wacc, racc, drop;
        bus.wr_en = w; bus.wr_data = d; bus.rd_en = r;
        bus.clr_overrun = c; bus.rst_soft = s;
        full_m = (mq.size() == DEPTH);
        wacc   = w && (!full_m || r);
        racc   = r && (mq.size() != 0);
        drop   = w && full_m && !r;
        @(posedge clk);
        if (s) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            if (racc) void'(mq.pop_front());
            if (wacc) mq.push_back(d);
            if (drop) m_ov = 1'b1;
            else if (c) m_ov = 1'b0;
        end
        if (s || wacc || racc || mq.size() == 0 || bus.bit_duration == 16'd0) m_idle = 0;
        else if (m_idle < 100000) m_idle++;
        #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_overrun = 1'b0; bus.rst_soft = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_en = 1'b0;
        bus.clr_overrun = 1'b0; bus.rst_soft = 1'b0; bus.bit_duration = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (dut_outs() !== 17'h0) $display("FAIL reset_outputs: got %h want %h", dut_outs(), 17'h0);
        else n_pass++;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        logic [7:0] bytes [3];
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        for (int i = 0; i < 3; i++) step(1'b1, bytes[i], 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({bus.rd_valid, bus.rd_data, bus.level} !== {1'b1, bytes[i], 5'(3 - i)})
                $display("FAIL basic_pop%0d: got v=%b d=%h l=%0d want d=%h l=%0d",
                         i, bus.rd_valid, bus.rd_data, bus.level, bytes[i], 3 - i);
            else n_pass++;
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        n_chk++;
        if ({bus.rd_valid, bus.rd_data, bus.level} !== 14'h0)
            $display("FAIL basic_empty: got v=%b d=%h l=%0d want 0/00/0",
                     bus.rd_valid, bus.rd_data, bus.level);
        else n_pass++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({bus.full, bus.overrun, bus.level} !== {1'b1, 1'b1, 5'd16})
            $display("FAIL overrun_drop: got full=%b ov=%b l=%0d want 1/1/16",
                     bus.full, bus.overrun, bus.level);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++;
            if (bus.rd_data !== 8'(i))
                $display("FAIL overrun_pop%0d: got %h want %h", i, bus.rd_data, 8'(i));
            else n_pass++;
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        n_chk++;
        if ({bus.rd_valid, bus.overrun} !== 2'b01)
            $display("FAIL overrun_drained: got v=%b ov=%b want 0/1", bus.rd_valid, bus.overrun);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (bus.overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_set_wins();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (bus.overrun !== 1'b1) $display("FAIL set_wins: got %b want 1", bus.overrun);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (dut_outs() !== m_outs()) $display("FAIL set_wins_clr: got %h want %h", dut_outs(), m_outs());
        else n_pass++;
    endtask

    task automatic test_full_both();
        // FIFO is full from test_set_wins.
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({bus.level, bus.overrun, bus.full} !== {5'd16, 1'b0, 1'b1})
            $display("FAIL full_both: got l=%0d ov=%b full=%b want 16/0/1",
                     bus.level, bus.overrun, bus.full);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++;
            if (dut_outs() !== m_outs())
                $display("FAIL full_both_pop%0d: got %h want %h", i, dut_outs(), m_outs());
            else n_pass++;
            if (i == DEPTH - 1) begin
                n_chk++;
                if (bus.rd_data !== 8'hAA) $display("FAIL full_both_last: got %h want aa", bus.rd_data);
                else n_pass++;
            end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_empty_both();
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({bus.level, bus.rd_valid, bus.rd_data} !== {5'd1, 1'b1, 8'h55})
            $display("FAIL empty_both: got l=%0d v=%b d=%h want 1/1/55",
                     bus.level, bus.rd_valid, bus.rd_data);
        else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({bus.level, bus.rd_valid, bus.overrun} !== 7'h0)
            $display("FAIL empty_pop: got l=%0d v=%b ov=%b want 0/0/0",
                     bus.level, bus.rd_valid, bus.overrun);
        else n_pass++;
    endtask

    task automatic test_soft_and_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        n_chk++;
        if (dut_outs() !== 17'h0) $display("FAIL soft_reset: got %h want %h", dut_outs(), 17'h0);
        else n_pass++;
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({bus.level, bus.rd_data} !== {5'd1, 8'h3C})
            $display("FAIL soft_reset_rewrite: got l=%0d d=%h want 1/3c", bus.level, bus.rd_data);
        else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (dut_outs() !== 17'h0) $display("FAIL async_reset: got %h want %h", dut_outs(), 17'h0);
        else n_pass++;
        #1 rst = 1'b0;
        model_clear();
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({bus.level, bus.rd_data} !== {5'd1, 8'hC3})
            $display("FAIL async_reset_rewrite: got l=%0d d=%h want 1/c3", bus.level, bus.rd_data);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        logic want;
        bus.bit_duration = 16'd4;
        step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 165; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (k == 159 || k == 160 || k == 165) begin
                want = TO_EN && (k >= 160);
                n_chk++;
                if (bus.timeout !== want)
                    $display("FAIL timeout_idle%0d: got %b want %b", k, bus.timeout, want);
                else n_pass++;
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if (bus.timeout !== 1'b0) $display("FAIL timeout_pop_clear: got %b want 0", bus.timeout);
        else n_pass++;
        bus.bit_duration = 16'd0;
        step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (200) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (bus.timeout !== 1'b0) $display("FAIL timeout_disabled: got %b want 0", bus.timeout);
        else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int unsigned wpct [4];
        int unsigned rpct [4];
        int unsigned bds  [4];
        int unsigned errs;
        wpct[0] = 50; wpct[1] = 30; wpct[2] = 75; wpct[3] = 3;
        rpct[0] = 30; rpct[1] = 50; rpct[2] = 20; rpct[3] = 2;
        bds[0]  = 0;  bds[1]  = 2;  bds[2]  = 3;  bds[3]  = 1;
        for (int p = 0; p < 4; p++) begin
            bus.bit_duration = 16'(bds[p]);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(99) < wpct[p], 8'($urandom), $urandom_range(99) < rpct[p],
                     $urandom_range(15) == 0, $urandom_range(127) == 0);
                errs = 0;
                n_chk++;
                if (dut_outs() !== m_outs()) begin
                    $display("FAIL random_p%0d_c%0d: got %h want %h", p, c, dut_outs(), m_outs());
                    errs++;
                end else n_pass++;
                if (errs != 0 && n_chk - n_pass > 20) begin
                    $display("FAIL random_abort: too many mismatches");
                    break;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_set_wins();
        test_full_both();
        test_empty_both();
        test_soft_and_async_reset();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Receive-side byte buffer between the UART RX deserializer and the CPU register interface.
- Accepts one-cycle write strobes carrying received bytes and holds up to 2**DEPTH_LOG2 of them.
- Presents the oldest byte to the CPU read path, with occupancy, full and sticky overrun status.
- Optionally flags an idle timeout, so software can drain partial bursts without polling every byte.

## Interface
- DATA_W, 8, byte width stored per entry.
- DEPTH_LOG2, 4, log2 of the entry count; depth = 16.
- BITDUR_W, 16, width of the bit-duration input, in clk cycles.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rst_soft  input  1  synchronous clear of pointers, level, overrun and timeout; same effect as rst, one cycle later.
- wr_en  input  1  one-cycle strobe from the deserializer: a byte was received.
- wr_data  input  DATA_W  received byte, sampled when wr_en=1.
- rd_en  input  1  CPU pop strobe, i.e. a valid read of the RX data address.
- rd_data  output  DATA_W  oldest entry; 0 when empty.
- rd_valid  output  1  FIFO not empty.
- level  output  DEPTH_LOG2+1  current entry count, 0..2**DEPTH_LOG2.
- full  output  1  level == 2**DEPTH_LOG2.
- overrun  output  1  sticky: a byte was dropped.
- clr_overrun  input  1  one-cycle clear of overrun.
- bit_duration  input  BITDUR_W  clk cycles per UART bit; the timeout is disabled when 0.
- timeout  output  1  idle-timeout flag; constant 0 unless configured.

## Operation
- Storage: flop array, write pointer and read pointer, each DEPTH_LOG2 bits; pointers wrap modulo depth.
- level is tracked explicitly, DEPTH_LOG2+1 bits wide.
- Write accepted when wr_en=1 and (not full, or rd_en=1 popping in the same cycle):
  - mem[wptr] <= wr_data;
  - wptr increments.
- Read accepted when rd_en=1 and level != 0: rptr increments.
- rd_data = mem[rptr] combinationally when level != 0, else 0.
- Level update: +1 on write only, -1 on read only, unchanged when both occur or neither occurs.
- Full with wr_en and rd_en in the same cycle: both accepted, level stays at depth, no overrun.
- Empty with wr_en and rd_en in the same cycle: write accepted, read ignored, level becomes 1.
- rd_en when empty: no effect, no error flag.
- Full with wr_en and no rd_en: the byte is dropped, contents are unchanged, and overrun <= 1.
- Overrun clearing:
  - clr_overrun=1 clears overrun.
  - If a drop occurs in the same cycle as clr_overrun, set wins.
- rst_soft has priority over wr_en, rd_en and clr_overrun in the same cycle.

## Timing
- Reset values: rd_data=0, rd_valid=0, level=0, full=0, overrun=0, timeout=0; pointers=0.
- Write-to-visible latency is 1 cycle. After a wr_en at edge N into an empty FIFO, rd_valid=1 and rd_data=byte after edge N.
- Pop latency is 1 cycle: after rd_en at edge N, rd_data shows the next entry.
- All status outputs are registered or derived only from registered state; no combinational path from wr_en or rd_en to any output.
- Asserting rst at any time, including mid-burst or while full, empties the FIFO immediately.

## Configuration
- Macro: UART_RX_TIMEOUT_EN.
- Defined: a bit-time prescaler counts bit_duration cycles. A bit counter counts `UART_RX_TIMEOUT_BITS (40, i.e. four 10-bit characters).
  - Both counters restart on any accepted write, any accepted read, rst_soft, or level == 0.
  - timeout goes to 1 when the bit count reaches 40 while level != 0.
  - timeout holds until the next accepted read, accepted write, rst_soft, or the FIFO becoming empty.
  - The counters saturate; they do not wrap.
  - bit_duration == 0 holds timeout at 0.
- Not defined: no counters are built; timeout is tied 0; bit_duration is ignored.

## Structure
- Defined in iob_uart.vh: `UART_RX_FIFO_DEPTH_LOG2 (default 4) and `UART_RX_TIMEOUT_BITS (40).
- Sub-module uart_rx_timeout holds the prescaler, the bit counter and the timeout flag. It is instantiated only under UART_RX_TIMEOUT_EN.
- uart_rx_fifo holds the storage, pointers, level and overrun.

## Test plan
- Write 0x41, 0x42, 0x43 on consecutive cycles, then pop 3 times -> rd_data reads 0x41, 0x42, 0x43; level goes 3,2,1,0; rd_valid=0 and rd_data=0 at the end.
- Fill 16 bytes 0x00..0x0F, then wr_en with 0xFF -> full=1, overrun=1, level=16. Pops return 0x00..0x0F; 0xFF is never returned. clr_overrun -> overrun=0.
- While full, simultaneous wr_en(0xAA) and rd_en -> level stays 16, overrun stays 0, and 0xAA is returned as the 16th pop.
- While empty, simultaneous wr_en(0x55) and rd_en -> level=1, rd_data=0x55 next cycle. rd_en alone while empty -> level stays 0.
- Write 5 bytes, assert rst_soft, and separately assert async rst mid-cycle -> all outputs return to reset values; the next write appears at pointer 0.
- With UART_RX_TIMEOUT_EN and bit_duration=4, write 1 byte and idle -> timeout=1 exactly 160 cycles after the write. A pop clears it. With bit_duration=0, timeout stays 0.
